// File: rtl/store_pkg.sv
// Shared types and lane-formation helper for the store path.
// Macro STORE_MISALIGN_SPLIT_EN adds the second-beat state for word-crossing stores.
package store_pkg;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam int ENT_ADDR_W = 32;

`ifdef STORE_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`else
  typedef enum logic [1:0] {IDLE, BEAT0} state_t;
`endif

  typedef struct packed {
    logic [ENT_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [1:0]            size;
  } store_ent_t;

  typedef struct packed {
    logic [63:0] sh;
    logic [7:0]  be;
  } lanes_t;

  // Spread data and byte mask across an 8-byte window starting at the word base.
  function automatic lanes_t form_lanes(input store_ent_t e);
    lanes_t     l;
    logic [3:0] mask;
    case (e.size)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    l.sh = {32'b0, e.data} << {e.addr[1:0], 3'b000};
    l.be = {4'b0, mask} << e.addr[1:0];
    return l;
  endfunction
endpackage

// File: rtl/store_buffer_fifo.sv
// In-order store buffer: DEPTH-entry synchronous FIFO exposing head and the entry behind it.
module store_buffer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [W-1:0] head_next,
  output logic         full,
  output logic         empty,
  output logic         many
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign do_push   = push & !full;
  assign do_pop    = pop & !empty;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign many      = (count > (PW+1)'(1));
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/store_unit.sv
// RISC-V store unit: buffers SB/SH/SW and drains lane-aligned word writes over req/gnt.
// Macro STORE_MISALIGN_SPLIT_EN: split word-crossing stores into two beats instead of dropping them.
module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in_st,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy,
  output logic              ill_func3,
  output logic              st_misaligned
);
  store_ent_t        din_ent, head, head_next, sel_ent;
  lanes_t            sel_lanes;
  state_t            state;
  logic              full, empty, many;
  logic              acc, is_store, f3_ok, push, pop;
  logic              sel_vld, ld, to_idle;
  logic [ADDR_W-1:0] beat0_addr;

  assign st_ready = !full & !rst;
  assign acc      = st_valid & st_ready;
  assign is_store = (op == OP_STORE);
  assign f3_ok    = (func3 == F3_SB) || (func3 == F3_SH) || (func3 == F3_SW);
  assign busy     = !empty | mem_req;

  assign din_ent.addr = ENT_ADDR_W'(addr);
  assign din_ent.data = data_in_st;
  assign din_ent.size = func3[1:0];

`ifdef STORE_MISALIGN_SPLIT_EN
  logic              split_q, to_b1;
  logic [ADDR_W-1:0] hi_addr;
  logic [31:0]       hi_wdata;
  logic [3:0]        hi_be;
  assign push = acc & is_store & f3_ok;
`else
  logic mis, unused_hi;
  assign mis  = ((func3 == F3_SH) && (addr[1:0] == 2'b11)) ||
                ((func3 == F3_SW) && (addr[1:0] != 2'b00));
  assign push = acc & is_store & f3_ok & !mis;
  assign unused_hi = ^{sel_lanes.sh[63:32], sel_lanes.be[7:4]};
`endif

  store_buffer_fifo #(.DEPTH(DEPTH), .W($bits(store_ent_t))) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din_ent),
    .head(head), .head_next(head_next), .full(full), .empty(empty), .many(many)
  );

  // Candidate for the next load: the buffer head as it will look after this cycle's push/pop.
  always_comb begin
    if (state == IDLE) begin
      sel_ent = empty ? din_ent : head;
      sel_vld = !empty | push;
    end else begin
      sel_ent = many ? head_next : din_ent;
      sel_vld = many | push;
    end
  end

  assign sel_lanes  = form_lanes(sel_ent);
  assign beat0_addr = ADDR_W'({sel_ent.addr[ENT_ADDR_W-1:2], 2'b00});

  always_comb begin
    ld      = 1'b0;
    to_idle = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    to_b1   = 1'b0;
`endif
    case (state)
      IDLE: ld = sel_vld;
      BEAT0: if (mem_gnt) begin
`ifdef STORE_MISALIGN_SPLIT_EN
        if (split_q) to_b1 = 1'b1;
        else
`endif
        if (sel_vld) ld = 1'b1;
        else         to_idle = 1'b1;
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      BEAT1: if (mem_gnt) begin
        if (sel_vld) ld = 1'b1;
        else         to_idle = 1'b1;
      end
`endif
      default: to_idle = 1'b1;
    endcase
  end

  assign pop = (ld | to_idle) & (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      ill_func3     <= 1'b0;
      st_misaligned <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
`endif
    end else begin
      ill_func3 <= acc & is_store & !f3_ok;
`ifdef STORE_MISALIGN_SPLIT_EN
      st_misaligned <= 1'b0;
`else
      st_misaligned <= acc & is_store & f3_ok & mis;
`endif
      if (ld) begin
        state     <= BEAT0;
        mem_req   <= 1'b1;
        mem_addr  <= beat0_addr;
        mem_wdata <= sel_lanes.sh[31:0];
        mem_be    <= sel_lanes.be[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
        hi_addr   <= beat0_addr + ADDR_W'(4);
        hi_wdata  <= sel_lanes.sh[63:32];
        hi_be     <= sel_lanes.be[7:4];
        split_q   <= |sel_lanes.be[7:4];
`endif
      end else if (to_idle) begin
        state     <= IDLE;
        mem_req   <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_be    <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
      end else if (to_b1) begin
        state     <= BEAT1;
        mem_addr  <= hi_addr;
        mem_wdata <= hi_wdata;
        mem_be    <= hi_be;
        split_q   <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit; split-mode vectors follow STORE_MISALIGN_SPLIT_EN.
module tb_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [6:0]  op = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] data_in_st = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        ill_func3;
  logic        st_misaligned;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OPS = 7'b0100011;

  store_unit #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .op(op),
    .func3(func3), .addr(addr), .data_in_st(data_in_st), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .busy(busy), .ill_func3(ill_func3), .st_misaligned(st_misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    st_valid   = v;
    op         = o;
    func3      = f;
    addr       = a;
    data_in_st = d;
  endtask

  task automatic idle_in();
    drive(1'b0, 7'd0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_ill", 32'(ill_func3), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(st_ready), 32'd1);

    // SB to byte 3
    mem_gnt = 1'b1;
    drive(1'b1, OPS, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    tick(); idle_in();
    chk("sb_req", 32'(mem_req), 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hDD00_0000);
    chk("sb_busy", 32'(busy), 32'd1);
    tick();
    chk("sb_done_req", 32'(mem_req), 32'd0);
    chk("sb_done_busy", 32'(busy), 32'd0);

    // SH to upper half, then a non-store opcode
    drive(1'b1, OPS, 3'b001, 32'h0000_2002, 32'h0000_1234);
    tick();
    drive(1'b1, 7'b0110011, 3'b000, 32'h0000_2100, 32'h5555_5555);
    chk("sh_addr", mem_addr, 32'h0000_2000);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'h1234_0000);
    tick(); idle_in();
    chk("nonst_req", 32'(mem_req), 32'd0);
    chk("nonst_busy", 32'(busy), 32'd0);
    chk("nonst_ill", 32'(ill_func3), 32'd0);
    chk("nonst_mis", 32'(st_misaligned), 32'd0);

    // SH at offset 1 stays within one word
    drive(1'b1, OPS, 3'b001, 32'h0000_5001, 32'h0000_BEEF);
    tick(); idle_in();
    chk("sh1_be", 32'(mem_be), 32'h6);
    chk("sh1_wdata", mem_wdata, 32'h00BE_EF00);
    chk("sh1_mis", 32'(st_misaligned), 32'd0);
    tick();
    chk("sh1_done", 32'(mem_req), 32'd0);

    // misaligned SW
    drive(1'b1, OPS, 3'b010, 32'h0000_3001, 32'h1122_3344);
    tick(); idle_in();
`ifdef STORE_MISALIGN_SPLIT_EN
    chk("sw_b0_addr", mem_addr, 32'h0000_3000);
    chk("sw_b0_be", 32'(mem_be), 32'hE);
    chk("sw_b0_wdata", mem_wdata, 32'h2233_4400);
    tick();
    chk("sw_b1_req", 32'(mem_req), 32'd1);
    chk("sw_b1_addr", mem_addr, 32'h0000_3004);
    chk("sw_b1_be", 32'(mem_be), 32'h1);
    chk("sw_b1_wdata", mem_wdata, 32'h0000_0011);
    tick();
    chk("sw_done", 32'(mem_req), 32'd0);
`else
    chk("sw_mis_pulse", 32'(st_misaligned), 32'd1);
    chk("sw_mis_req", 32'(mem_req), 32'd0);
    chk("sw_mis_busy", 32'(busy), 32'd0);
    tick();
    chk("sw_mis_clear", 32'(st_misaligned), 32'd0);
    chk("sw_mis_req2", 32'(mem_req), 32'd0);
`endif

    // fill the buffer with the memory stalled
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OPS, 3'b010, 32'h0000_4000 + 32'(4 * i), 32'hA0A0_0000 + 32'(i));
      tick();
    end
    chk("full_ready", 32'(st_ready), 32'd0);
    drive(1'b1, OPS, 3'b010, 32'h0000_4010, 32'hA0A0_0004);
    tick();
    chk("full_ready2", 32'(st_ready), 32'd0);
    chk("stall_req", 32'(mem_req), 32'd1);
    chk("stall_addr", mem_addr, 32'h0000_4000);
    chk("stall_wdata", mem_wdata, 32'hA0A0_0000);
    idle_in();
    mem_gnt = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("b2b_req", 32'(mem_req), 32'd1);
      chk("b2b_addr", mem_addr, 32'h0000_4000 + 32'(4 * i));
      chk("b2b_wdata", mem_wdata, 32'hA0A0_0000 + 32'(i));
    end
    tick();
    chk("drain_req", 32'(mem_req), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    // reserved func3
    drive(1'b1, OPS, 3'b011, 32'h0000_7000, 32'h1234_5678);
    tick(); idle_in();
    chk("ill_pulse", 32'(ill_func3), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_req", 32'(mem_req), 32'd0);
    tick();
    chk("ill_clear", 32'(ill_func3), 32'd0);

    // SW crossing the top of the address space
    drive(1'b1, OPS, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    tick(); idle_in();
`ifdef STORE_MISALIGN_SPLIT_EN
    chk("wrap_b0_addr", mem_addr, 32'hFFFF_FFFC);
    chk("wrap_b0_be", 32'(mem_be), 32'hC);
    chk("wrap_b0_wdata", mem_wdata, 32'hF00D_0000);
    tick();
    chk("wrap_b1_addr", mem_addr, 32'h0000_0000);
    chk("wrap_b1_be", 32'(mem_be), 32'h3);
    chk("wrap_b1_wdata", mem_wdata, 32'h0000_CAFE);
    tick();
`else
    chk("wrap_mis", 32'(st_misaligned), 32'd1);
    chk("wrap_req", 32'(mem_req), 32'd0);
    tick();
`endif

    // reset while a beat is stalled
    mem_gnt = 1'b0;
    drive(1'b1, OPS, 3'b000, 32'h0000_6000, 32'h0000_0055);
    tick(); idle_in();
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    chk("pre_rst_wdata", mem_wdata, 32'h0000_0055);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(st_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("after_rst_ready", 32'(st_ready), 32'd1);
    chk("after_rst_req", 32'(mem_req), 32'd0);
    chk("after_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
